pipe_seq_ctrl: RTL and testbench

- Parametrised fetch/sequencing controller for the 3-stage (IF/ID, EX, WB) processor pipeline.
- Owns the PC, the PC_ID and PC_EX shadow registers, stall/flush generation, halt, and vectored multi-source interrupt injection.
- Replaces the hard-wired single-IFF, fixed-vector, 12-bit sequencing in the core top level.
- The core top level instantiates it and uses inject_valid/inject_vec to override IR with a JSR.

---
 rtl/pipe_seq_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/pipe_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_seq_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

  localparam logic [15:0] NOP_INSTR          = 16'hFFFF;
  localparam logic [3:0]  JSR_OPCODE         = 4'b1000;
  localparam int unsigned VEC_BASE_DEFAULT   = 512;
  localparam int unsigned VEC_STRIDE_DEFAULT = 16;
  localparam int unsigned NEST_DEPTH         = 4;

  // Vector address before truncation to the address width.
  function automatic logic [31:0] vec_addr(input int unsigned base, input int unsigned stride,
                                           input int unsigned idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: bit 0 wins; gives any-valid, binary index and one-hot grant.
module irq_prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign onehot = req & ~(req - N'(1));

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Fetch/sequencing controller: PC shadows, stall/flush, halt and vectored IRQ injection.
// Optional nested interrupts are enabled by defining PIPE_SEQ_NEST_EN.
module pipe_seq_ctrl
  import pipe_seq_pkg::*;
#(
  parameter int unsigned AW         = 12,
  parameter int unsigned NIRQ       = 4,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEFAULT,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEFAULT,
  parameter int unsigned DEPTH_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_mode,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [AW-1:0]   br_target,
  input  logic            jsr_ex,
  input  logic            ret_ex,
  input  logic [AW-1:0]   ret_target,
  input  logic            halt_ex,
  input  logic [NIRQ-1:0] irq,
  input  logic [NIRQ-1:0] irq_mask,
  output logic [AW-1:0]   pc,
  output logic [AW-1:0]   pc_id,
  output logic [AW-1:0]   pc_ex,
  output logic            flush,
  output logic            inject_valid,
  output logic [AW-1:0]   inject_vec,
  output logic [NIRQ-1:0] irq_ack,
  output logic            int_active,
  output logic            halted
);

  localparam int unsigned IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  seq_state_e         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_id_q, pc_ex_q, pc_next;
  logic [NIRQ-1:0]    pending_q, pending_d, pend_en, enc_onehot, ack;
  logic [DEPTH_W-1:0] depth_q, depth_d, depth_t;
  logic               skip_q, skip_d, skip_t;
  logic               active_q, active_d;
  logic               adv, flush_c, inj, nest_ok, enc_valid;
  logic [IW-1:0]      enc_idx;

  assign pend_en = pending_q & irq_mask;

  irq_prio_enc #(
    .N  (NIRQ),
    .IW (IW)
  ) u_prio (
    .req    (pend_en),
    .valid  (enc_valid),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  assign adv     = reset & ~load_mode & ~stall & (state_q != HALT);
  assign flush_c = reset & (ret_ex | br_valid | halt_ex | (state_q == HALT));
  assign inj     = (state_q == RUN) & adv & ~flush_c & enc_valid & (~active_q | nest_ok);
  assign ack     = inj ? enc_onehot : '0;

  always_comb begin
    pc_next = pc_q + AW'(1);
    if (ret_ex) begin
      pc_next = ret_target + AW'(1);
    end else if (br_valid) begin
      pc_next = br_target;
    end
  end

`ifdef PIPE_SEQ_NEST_EN
  localparam int unsigned SP_W = 3;
  logic [IW-1:0]      act_idx_q, act_idx_d;
  logic [IW-1:0]      nest_idx_q   [NEST_DEPTH];
  logic [DEPTH_W-1:0] nest_depth_q [NEST_DEPTH];
  logic               nest_skip_q  [NEST_DEPTH];
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [1:0]         top_ptr, push_ptr;
  logic               push, pop;

  assign top_ptr  = 2'(sp_q - SP_W'(1));
  assign push_ptr = 2'(sp_q);
  assign nest_ok  = active_q & (sp_q != SP_W'(NEST_DEPTH)) & (enc_idx < act_idx_q);
`else
  assign nest_ok = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    depth_t   = depth_q;
    skip_t    = skip_q;
`ifdef PIPE_SEQ_NEST_EN
    act_idx_d = act_idx_q;
    push      = 1'b0;
    pop       = 1'b0;
`endif
    if (!load_mode) begin
      pending_d = (pending_q | (irq & irq_mask)) & ~ack;
      unique case (state_q)
        RUN:     if (halt_ex && adv) state_d = HALT;
        HALT:    if (|pend_en) state_d = RUN;
        default: state_d = RUN;
      endcase
      if (active_q) begin
        if (ret_ex) begin
          if (depth_q != '0) begin
            depth_t = depth_q - DEPTH_W'(1);
          end else begin
`ifdef PIPE_SEQ_NEST_EN
            if (sp_q != '0) begin
              pop       = 1'b1;
              act_idx_d = nest_idx_q[top_ptr];
              depth_t   = nest_depth_q[top_ptr];
              skip_t    = nest_skip_q[top_ptr];
            end else begin
              active_d = 1'b0;
            end
`else
            active_d = 1'b0;
`endif
          end
        end else if (jsr_ex) begin
          // The first JSR after injection is the injected one and is not a call level.
          if (skip_q) begin
            skip_t = 1'b0;
          end else if (depth_q != '1) begin
            depth_t = depth_q + DEPTH_W'(1);
          end
        end
      end
    end
    depth_d = depth_t;
    skip_d  = skip_t;
    if (inj) begin
`ifdef PIPE_SEQ_NEST_EN
      push      = active_q;
      act_idx_d = enc_idx;
`endif
      active_d = 1'b1;
      depth_d  = '0;
      skip_d   = 1'b1;
    end
  end

`ifdef PIPE_SEQ_NEST_EN
  assign sp_d = sp_q + SP_W'(push) - SP_W'(pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q      <= '0;
      act_idx_q <= '0;
    end else begin
      sp_q      <= sp_d;
      act_idx_q <= act_idx_d;
      if (push) begin
        nest_idx_q[push_ptr]   <= act_idx_q;
        nest_depth_q[push_ptr] <= depth_t;
        nest_skip_q[push_ptr]  <= skip_t;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      pc_id_q   <= '0;
      pc_ex_q   <= '0;
      pending_q <= '0;
      active_q  <= 1'b0;
      depth_q   <= '0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      depth_q   <= depth_d;
      skip_q    <= skip_d;
      if (adv) begin
        pc_ex_q <= pc_id_q;
        pc_id_q <= pc_q;
        pc_q    <= pc_next;
      end
    end
  end

  assign pc           = pc_q;
  assign pc_id        = pc_id_q;
  assign pc_ex        = pc_ex_q;
  assign flush        = flush_c;
  assign inject_valid = inj;
  assign inject_vec   = inj ? AW'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(enc_idx))) : '0;
  assign irq_ack      = ack;
  assign int_active   = active_q;
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: directed scenarios then randomized traffic vs a model.
module tb_pipe_seq_ctrl;

  typedef struct {
    logic [11:0] pc, pc_id, pc_ex, vec;
    logic [3:0]  ack;
    logic        fl, iv, act, hlt;
  } rec_t;

  typedef struct {
    logic [11:0] vec;
    logic [3:0]  ack;
  } inj_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0, load_mode = 1'b0, stall = 1'b0, br_valid = 1'b0;
  logic        jsr_ex = 1'b0, ret_ex = 1'b0, halt_ex = 1'b0;
  logic [11:0] br_target = '0, ret_target = '0;
  logic [3:0]  irq = '0, irq_mask = '0;
  logic [11:0] d_pc, d_pc_id, d_pc_ex, d_vec;
  logic [3:0]  d_ack;
  logic        d_flush, d_inj, d_act, d_halted;

  // Staged stimulus, applied to the DUT on the next tick.
  logic        s_rst, s_lm, s_st, s_brv, s_jsr, s_ret, s_hlt;
  logic [11:0] s_brt, s_rtt;
  logic [3:0]  s_irq, s_mask;

  // Reference model state.
  logic [11:0] m_pc, m_pc_id, m_pc_ex;
  logic [3:0]  m_pend;
  bit          m_halt, m_active, m_skip, m_valid = 1'b0;
  int          m_depth;

  rec_t cyc_q[$];
  inj_t inj_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_seq_ctrl #(
    .AW         (12),
    .NIRQ       (4),
    .VEC_BASE   (512),
    .VEC_STRIDE (16),
    .DEPTH_W    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_mode    (load_mode),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .jsr_ex       (jsr_ex),
    .ret_ex       (ret_ex),
    .ret_target   (ret_target),
    .halt_ex      (halt_ex),
    .irq          (irq),
    .irq_mask     (irq_mask),
    .pc           (d_pc),
    .pc_id        (d_pc_id),
    .pc_ex        (d_pc_ex),
    .flush        (d_flush),
    .inject_valid (d_inj),
    .inject_vec   (d_vec),
    .irq_ack      (d_ack),
    .int_active   (d_act),
    .halted       (d_halted)
  );

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endfunction

  task automatic clr();
    s_rst = 1'b1; s_lm = 1'b0; s_st = 1'b0; s_brv = 1'b0; s_jsr = 1'b0; s_ret = 1'b0;
    s_hlt = 1'b0; s_brt = '0; s_rtt = '0; s_irq = '0; s_mask = 4'hF;
  endtask

  // One clock: apply staged inputs, queue the predicted response, advance the model.
  task automatic tick();
    rec_t        e;
    inj_t        ij;
    int          sel;
    logic [3:0]  pe, ackv;
    logic [11:0] vec;
    bit          fl, go, inj;
    @(posedge clk);
    #1;
    pe  = m_pend & s_mask;
    fl  = s_rst && (s_ret || s_brv || s_hlt || m_halt);
    go  = s_rst && !s_lm && !s_st && !m_halt;
    sel = -1;
    for (int i = 3; i >= 0; i--) if (pe[i]) sel = i;
    inj  = go && !fl && !m_active && (sel >= 0);
    ackv = inj ? 4'(1 << sel) : 4'b0;
    vec  = inj ? 12'((512 + sel * 16) % 4096) : 12'h0;
    // Keep a source quiet in its own ack cycle so set-vs-clear ordering never matters.
    s_irq = s_irq & ~ackv;
    reset = s_rst; load_mode = s_lm; stall = s_st; br_valid = s_brv; br_target = s_brt;
    jsr_ex = s_jsr; ret_ex = s_ret; ret_target = s_rtt; halt_ex = s_hlt;
    irq = s_irq; irq_mask = s_mask;
    if (m_valid) begin
      e.pc = m_pc; e.pc_id = m_pc_id; e.pc_ex = m_pc_ex; e.vec = vec; e.ack = ackv;
      e.fl = fl; e.iv = inj; e.act = m_active; e.hlt = m_halt;
      cyc_q.push_back(e);
      if (inj) begin
        ij.vec = vec; ij.ack = ackv;
        inj_q.push_back(ij);
      end
    end
    if (!s_rst) begin
      m_pc = 0; m_pc_id = 0; m_pc_ex = 0; m_pend = 0;
      m_halt = 0; m_active = 0; m_skip = 0; m_depth = 0; m_valid = 1'b1;
    end else begin
      if (go) begin
        m_pc_ex = m_pc_id;
        m_pc_id = m_pc;
        m_pc    = s_ret ? s_rtt + 12'd1 : (s_brv ? s_brt : m_pc + 12'd1);
      end
      if (!s_lm) begin
        if (m_halt) begin
          if (pe != 0) m_halt = 0;
        end else if (s_hlt && go) begin
          m_halt = 1;
        end
        if (m_active) begin
          if (s_ret) begin
            if (m_depth > 0) m_depth--;
            else m_active = 0;
          end else if (s_jsr) begin
            if (m_skip) m_skip = 0;
            else if (m_depth < 15) m_depth++;
          end
        end
        m_pend = (m_pend | (s_irq & s_mask)) & ~ackv;
        if (inj) begin
          m_active = 1; m_depth = 0; m_skip = 1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compares every presented cycle, plus each injection against the inject queue.
  initial begin
    rec_t e;
    inj_t ij;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("pc", 32'(d_pc), 32'(e.pc));
        chk("pc_id", 32'(d_pc_id), 32'(e.pc_id));
        chk("pc_ex", 32'(d_pc_ex), 32'(e.pc_ex));
        chk("flush", 32'(d_flush), 32'(e.fl));
        chk("inject_valid", 32'(d_inj), 32'(e.iv));
        chk("int_active", 32'(d_act), 32'(e.act));
        chk("halted", 32'(d_halted), 32'(e.hlt));
        chk("irq_ack_idle", 32'(d_inj ? 4'h0 : d_ack), 32'(e.iv ? 4'h0 : e.ack));
      end
      if (d_inj === 1'b1) begin
        if (inj_q.size() == 0) begin
          chk("unexpected_inject", 32'(d_vec), 32'hFFFF_FFFF);
        end else begin
          ij = inj_q.pop_front();
          chk("inject_vec", 32'(d_vec), 32'(ij.vec));
          chk("irq_ack", 32'(d_ack), 32'(ij.ack));
        end
      end
    end
  end

  initial begin
    clr();
    s_rst = 1'b0;
    run(2);
    s_rst = 1'b1;
    run(7);                                   // pc walks 0..7
    s_st = 1'b1; run(3); s_st = 1'b0; run(1); // hold at 7, then 8
    s_brv = 1'b1; s_brt = 12'h010; run(1);
    s_brt = 12'h0A0; run(1);
    s_ret = 1'b1; s_rtt = 12'h050; run(1);    // ret beats branch -> 0x051
    clr(); run(2);
    // Two simultaneous sources: 1 goes first, 3 after the ISR ends.
    s_irq = 4'b1010; run(1); s_irq = 4'b0000; run(3);
    s_jsr = 1'b1; run(1); s_jsr = 1'b0; run(1);
    s_lm = 1'b1; s_jsr = 1'b1; run(2); s_lm = 1'b0;
    run(1); s_jsr = 1'b0;                     // nested call
    s_ret = 1'b1; s_rtt = 12'h123; run(1); s_ret = 1'b0; run(2);
    s_ret = 1'b1; s_rtt = 12'h200; run(1); s_ret = 1'b0; run(2);
    s_jsr = 1'b1; run(1); s_jsr = 1'b0; run(1);
    s_ret = 1'b1; s_rtt = 12'h300; run(1); s_ret = 1'b0; run(2);
    // Halt, frozen, then woken by source 2.
    s_hlt = 1'b1; run(1); s_hlt = 1'b0; run(10);
    s_irq = 4'b0100; run(1); s_irq = 4'b0000; run(3);
    s_jsr = 1'b1; run(1); s_jsr = 1'b0;
    s_ret = 1'b1; s_rtt = 12'h040; run(1); s_ret = 1'b0; run(2);
    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s_rst  = ($urandom_range(499) != 0);
      s_lm   = ($urandom_range(19) == 0);
      s_st   = ($urandom_range(7) == 0);
      s_brv  = ($urandom_range(9) == 0);
      s_brt  = 12'($urandom);
      s_ret  = !s_st && ($urandom_range(11) == 0);
      s_jsr  = !s_st && ($urandom_range(9) == 0);
      s_rtt  = 12'($urandom);
      s_hlt  = ($urandom_range(39) == 0);
      s_irq  = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      s_mask = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      run(1);
    end
    clr(); run(1);
    @(negedge clk);
    #1;
    chk("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    chk("inject_queue_drained", 32'(inj_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
